// File: rtl/lif_stim_pkg.sv
// Shared types and default widths for the LIF spike-train stimulus generator.
package lif_stim_pkg;

  localparam int DEF_CFG_W = 16;
  localparam int DEF_MEM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/lif_period_timer.sv
// Period counter for the input spike train. tick is registered: it is high in
// exactly the RUN cycles whose counter value equals eff_period-1.
module lif_period_timer #(
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [PER_W-1:0] eff_period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [PER_W-1:0] last_cnt;

  assign last_cnt = eff_period - PER_W'(1);

  // clear/run describe the *next* cycle, so tick_d is a look-ahead of the spike.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + PER_W'(1);
    end
    tick_d = (clear || run) && (cnt_d == last_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/lif_stim_gen.sv
// Plays one periodic input spike train per command into a LIF neuron, then
// reports the output-spike count and peak membrane potential after a drain window.
module lif_stim_gen
  import lif_stim_pkg::*;
#(
  parameter int CFG_W        = DEF_CFG_W,
  parameter int MEM_W        = DEF_MEM_W,
  parameter int PER_W        = 8,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CFG_W-1:0] cmd_config,
  input  logic [PER_W-1:0] cmd_period,
  input  logic [CNT_W-1:0] cmd_num_spikes,
  input  logic             abort,
  output logic             enable,
  output logic             input_spike,
  output logic [CFG_W-1:0] neuron_config,
  input  logic             output_spike,
  input  logic [MEM_W-1:0] membrane_potential,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] out_spike_count,
  output logic [MEM_W-1:0] peak_potential
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q;
  logic [PER_W-1:0] period_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] sent_q;
  logic [DW-1:0]    drain_q;
  logic             ready_q;
  logic             enable_q;
  logic             done_q;
  logic             aborted_q;
  logic [CNT_W-1:0] count_q;
  logic [MEM_W-1:0] peak_q;

  logic             accept;
  logic             abort_taken;
  logic             last_spike;
  logic             observe;
  logic             timer_clear;
  logic             timer_run;
  logic [PER_W-1:0] eff_period;

  assign cmd_ready   = ready_q & ~rst;
  assign accept      = cmd_valid & cmd_ready;
  assign eff_period  = (period_q == '0) ? PER_W'(1) : period_q;
  assign abort_taken = abort && (state_q inside {ST_LOAD, ST_RUN, ST_DRAIN});
  assign last_spike  = input_spike &&
                       (({1'b0, sent_q} + (CNT_W + 1)'(1)) == {1'b0, num_q});
  assign observe     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign timer_clear = (state_q == ST_LOAD) && (state_d == ST_RUN);
  assign timer_run   = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  if (abort) state_d = ST_DONE;
                else if (num_q == '0) state_d = ST_DRAIN;
                else state_d = ST_RUN;
      ST_RUN:   if (abort) state_d = ST_DONE;
                else if (last_spike) state_d = ST_DRAIN;
      ST_DRAIN: if (abort) state_d = ST_DONE;
                else if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  lif_period_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .run        (timer_run),
    .eff_period (eff_period),
    .tick       (input_spike)
  );

  // Control outputs are computed from state_d so they line up with the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_q     <= '0;
      period_q  <= '0;
      num_q     <= '0;
      sent_q    <= '0;
      drain_q   <= '0;
      count_q   <= '0;
      peak_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      enable_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      aborted_q <= abort_taken;
      drain_q   <= (state_q == ST_DRAIN) ? drain_q + DW'(1) : '0;
      if (accept) begin
        cfg_q    <= cmd_config;
        period_q <= cmd_period;
        num_q    <= cmd_num_spikes;
        sent_q   <= '0;
        count_q  <= '0;
        peak_q   <= '0;
      end
      if ((state_q == ST_RUN) && input_spike) begin
        sent_q <= sent_q + CNT_W'(1);
      end
      // An output spike in an aborting cycle is still counted.
      if (observe) begin
        if (output_spike && (count_q != {CNT_W{1'b1}})) begin
          count_q <= count_q + CNT_W'(1);
        end
        if (membrane_potential > peak_q) begin
          peak_q <= membrane_potential;
        end
      end
    end
  end

  assign enable          = enable_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign neuron_config   = cfg_q;
  assign out_spike_count = count_q;
  assign peak_potential  = peak_q;

endmodule

// File: tb/tb_lif_stim_gen.sv
// Self-checking bench for lif_stim_gen: scoreboard of expected done/spike cycles
// plus a small observation model of output-spike count and peak potential.
module tb_lif_stim_gen;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_config;
  logic [7:0]  cmd_period;
  logic [7:0]  cmd_num_spikes;
  logic        abort;
  logic        enable;
  logic        input_spike;
  logic [15:0] neuron_config;
  logic        output_spike;
  logic [15:0] membrane_potential;
  logic        done;
  logic        aborted;
  logic [7:0]  out_spike_count;
  logic [15:0] peak_potential;

  lif_stim_gen #(
    .CFG_W(16), .MEM_W(16), .PER_W(8), .CNT_W(8), .DRAIN_CYCLES(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_config         (cmd_config),
    .cmd_period         (cmd_period),
    .cmd_num_spikes     (cmd_num_spikes),
    .abort              (abort),
    .enable             (enable),
    .input_spike        (input_spike),
    .neuron_config      (neuron_config),
    .output_spike       (output_spike),
    .membrane_potential (membrane_potential),
    .done               (done),
    .aborted            (aborted),
    .out_spike_count    (out_spike_count),
    .peak_potential     (peak_potential)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] done_cyc;
    logic        ab;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_spk_q[$];
  int          obs_spk[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          obs_done, en_first, en_last, en_n, model_cnt, win_lo, win_hi;
  logic        obs_ab;
  logic [7:0]  obs_cnt;
  logic [15:0] obs_pk, cfg_load, model_pk;

  // Drive one command in the current cycle; returns the accept cycle.
  task automatic issue(input logic [15:0] cfg, input logic [7:0] per,
                       input logic [7:0] num, output int t);
    cmd_valid = 1'b1; cmd_config = cfg; cmd_period = per; cmd_num_spikes = num;
    t = cyc;
  endtask

  // Runs cycles until done (or the bound), driving neuron-side stimulus and
  // recording what the DUT produced. Mode 0: quiet, 1: sparse spikes with
  // random potential, 2: 300-cycle output spike burst with a 0x7F00-peak ramp.
  task automatic collect(input int t0, input int mode, input int abort_at, input int bound);
    int c, rel;
    obs_spk.delete();
    obs_done = -1; obs_ab = 1'b0; obs_cnt = '0; obs_pk = '0; cfg_load = '0;
    en_first = -1; en_last = -1; en_n = 0; model_cnt = 0; model_pk = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      c = cyc;
      cmd_valid = 1'b0;
      if (input_spike) obs_spk.push_back(c);
      if (enable) begin
        if (en_first < 0) en_first = c;
        en_last = c;
        en_n++;
      end
      if (c == t0 + 1) cfg_load = neuron_config;
      if (done) begin
        obs_done = c; obs_ab = aborted; obs_cnt = out_spike_count; obs_pk = peak_potential;
        abort = 1'b0; output_spike = 1'b0; membrane_potential = '0;
        break;
      end
      abort = (c == abort_at);
      rel = c - (t0 + 2);
      case (mode)
        1: begin
          output_spike = (c % 3 == 0) || (c == abort_at);
          membrane_potential = 16'($urandom_range(0, 65535));
        end
        2: begin
          output_spike = (rel >= 0) && (rel < 300);
          if (rel < 0) membrane_potential = '0;
          else if (rel <= 127) membrane_potential = 16'(rel * 256);
          else if (rel < 254) membrane_potential = 16'((254 - rel) * 256);
          else membrane_potential = '0;
        end
        default: begin
          output_spike = 1'b0;
          membrane_potential = '0;
        end
      endcase
      if (c >= win_lo && c <= win_hi) begin
        if (output_spike && model_cnt < 255) model_cnt++;
        if (membrane_potential > model_pk) model_pk = membrane_potential;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_in_rst: got %b want 0", cmd_ready); end
    n_checks++; if ({enable, input_spike, done, aborted} !== 4'b0) begin n_errors++; $display("FAIL reset_ctrl: en/spk/done/ab=%b want 0000", {enable, input_spike, done, aborted}); end
    n_checks++; if (neuron_config !== 16'h0) begin n_errors++; $display("FAIL reset_config: got %h want 0000", neuron_config); end
    n_checks++; if ({out_spike_count, peak_potential} !== 24'h0) begin n_errors++; $display("FAIL reset_results: cnt=%0d peak=%h want 0", out_spike_count, peak_potential); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    int t, e, o;
    exp_t ex;
    issue(16'h1234, 8'd4, 8'd3, t);
    ex.done_cyc = 32'(t + 22); ex.ab = 1'b0; exp_q.push_back(ex);
    for (int k = 1; k <= 3; k++) exp_spk_q.push_back(t + 1 + 4 * k);
    win_lo = t + 2; win_hi = t + 21;
    collect(t, 1, -1, 60);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL basic_done: at T+%0d want T+%0d", obs_done - t, int'(ex.done_cyc) - t); end
    n_checks++; if (obs_ab !== ex.ab) begin n_errors++; $display("FAIL basic_aborted: got %b want %b", obs_ab, ex.ab); end
    n_checks++; if (cfg_load !== 16'h1234) begin n_errors++; $display("FAIL basic_config: got %h want 1234", cfg_load); end
    n_checks++; if (obs_cnt !== 8'(model_cnt)) begin n_errors++; $display("FAIL basic_count: got %0d want %0d", obs_cnt, model_cnt); end
    n_checks++; if (obs_pk !== model_pk) begin n_errors++; $display("FAIL basic_peak: got %h want %h", obs_pk, model_pk); end
    while (exp_spk_q.size() > 0) begin
      e = exp_spk_q.pop_front();
      o = (obs_spk.size() > 0) ? obs_spk.pop_front() : -1;
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL basic_spike: at T+%0d want T+%0d", o - t, e - t); end
    end
    n_checks++; if (obs_spk.size() !== 0) begin n_errors++; $display("FAIL basic_extra_spikes: got %0d want 0", obs_spk.size()); end
    $display("basic: cfg=1234 per=4 num=3 done=T+%0d cnt=%0d peak=%h", obs_done - t, obs_cnt, obs_pk);
  endtask

  task automatic test_zero_spikes();
    int t;
    exp_t ex;
    issue(16'h00A5, 8'd5, 8'd0, t);
    ex.done_cyc = 32'(t + 10); ex.ab = 1'b0; exp_q.push_back(ex);
    win_lo = t + 2; win_hi = t + 9;
    collect(t, 0, -1, 40);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL zero_done: at T+%0d want T+%0d", obs_done - t, int'(ex.done_cyc) - t); end
    n_checks++; if (obs_spk.size() !== 0) begin n_errors++; $display("FAIL zero_spikes: got %0d want 0", obs_spk.size()); end
    n_checks++; if (en_first !== t + 2 || en_last !== t + 9 || en_n !== 8) begin n_errors++; $display("FAIL zero_enable: T+%0d..T+%0d n=%0d want T+2..T+9 n=8", en_first - t, en_last - t, en_n); end
    n_checks++; if (obs_ab !== ex.ab) begin n_errors++; $display("FAIL zero_aborted: got %b want %b", obs_ab, ex.ab); end
    $display("zero_spikes: per=5 num=0 done=T+%0d enable T+%0d..T+%0d", obs_done - t, en_first - t, en_last - t);
  endtask

  task automatic test_period_zero();
    int t, e, o;
    exp_t ex;
    issue(16'h0F0F, 8'd0, 8'd4, t);
    ex.done_cyc = 32'(t + 14); ex.ab = 1'b0; exp_q.push_back(ex);
    for (int k = 0; k < 4; k++) exp_spk_q.push_back(t + 2 + k);
    win_lo = t + 2; win_hi = t + 13;
    collect(t, 1, -1, 40);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL per0_done: at T+%0d want T+%0d", obs_done - t, int'(ex.done_cyc) - t); end
    n_checks++; if (obs_cnt !== 8'(model_cnt)) begin n_errors++; $display("FAIL per0_count: got %0d want %0d", obs_cnt, model_cnt); end
    while (exp_spk_q.size() > 0) begin
      e = exp_spk_q.pop_front();
      o = (obs_spk.size() > 0) ? obs_spk.pop_front() : -1;
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL per0_spike: at T+%0d want T+%0d", o - t, e - t); end
    end
    n_checks++; if (obs_spk.size() !== 0) begin n_errors++; $display("FAIL per0_extra_spikes: got %0d want 0", obs_spk.size()); end
    $display("period_zero: per=0 num=4 done=T+%0d cnt=%0d", obs_done - t, obs_cnt);
  endtask

  task automatic test_abort_back_to_back();
    int t, t2, e, o;
    exp_t ex;
    issue(16'hCAFE, 8'd4, 8'd3, t);
    ex.done_cyc = 32'(t + 4); ex.ab = 1'b1; exp_q.push_back(ex);
    win_lo = t + 2; win_hi = t + 3;
    collect(t, 1, t + 3, 30);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL abort_done: at T+%0d want T+%0d", obs_done - t, int'(ex.done_cyc) - t); end
    n_checks++; if (obs_ab !== ex.ab) begin n_errors++; $display("FAIL abort_aborted: got %b want %b", obs_ab, ex.ab); end
    n_checks++; if (obs_spk.size() !== 0) begin n_errors++; $display("FAIL abort_spikes: got %0d want 0", obs_spk.size()); end
    n_checks++; if (obs_cnt !== 8'(model_cnt)) begin n_errors++; $display("FAIL abort_count: got %0d want %0d", obs_cnt, model_cnt); end
    $display("abort: done=T+%0d aborted=%b cnt=%0d", obs_done - t, obs_ab, obs_cnt);
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    n_checks++; if (neuron_config !== 16'hCAFE) begin n_errors++; $display("FAIL idle_config_hold: got %h want cafe", neuron_config); end
    issue(16'h5A5A, 8'd2, 8'd2, t2);
    ex.done_cyc = 32'(t2 + 14); ex.ab = 1'b0; exp_q.push_back(ex);
    exp_spk_q.push_back(t2 + 3); exp_spk_q.push_back(t2 + 5);
    win_lo = t2 + 2; win_hi = t2 + 13;
    collect(t2, 0, -1, 40);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL b2b_done: at T+%0d want T+%0d", obs_done - t2, int'(ex.done_cyc) - t2); end
    n_checks++; if (obs_ab !== ex.ab) begin n_errors++; $display("FAIL b2b_aborted: got %b want %b", obs_ab, ex.ab); end
    n_checks++; if (cfg_load !== 16'h5A5A) begin n_errors++; $display("FAIL b2b_config: got %h want 5a5a", cfg_load); end
    while (exp_spk_q.size() > 0) begin
      e = exp_spk_q.pop_front();
      o = (obs_spk.size() > 0) ? obs_spk.pop_front() : -1;
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL b2b_spike: at T+%0d want T+%0d", o - t2, e - t2); end
    end
    $display("back_to_back: accepted at abort+1 done=T+%0d", obs_done - t2);
  endtask

  task automatic test_saturate();
    int t;
    exp_t ex;
    issue(16'h7777, 8'd100, 8'd3, t);
    ex.done_cyc = 32'(t + 310); ex.ab = 1'b0; exp_q.push_back(ex);
    win_lo = t + 2; win_hi = t + 309;
    collect(t, 2, -1, 400);
    ex = exp_q.pop_front();
    n_checks++; if (obs_done !== int'(ex.done_cyc)) begin n_errors++; $display("FAIL sat_done: at T+%0d want T+%0d", obs_done - t, int'(ex.done_cyc) - t); end
    n_checks++; if (obs_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_count: got %0d want 255", obs_cnt); end
    n_checks++; if (obs_pk !== 16'h7F00) begin n_errors++; $display("FAIL sat_peak: got %h want 7f00", obs_pk); end
    n_checks++; if (obs_spk.size() !== 3) begin n_errors++; $display("FAIL sat_spikes: got %0d want 3", obs_spk.size()); end
    $display("saturate: cnt=%0d peak=%h", obs_cnt, obs_pk);
  endtask

  task automatic test_reset_mid_run();
    int t, seen_done;
    @(negedge clk);
    issue(16'hBEEF, 8'd4, 8'd3, t);
    @(negedge clk);
    cmd_valid = 1'b0; output_spike = 1'b1; membrane_potential = 16'h0321;
    repeat (5) @(negedge clk);
    n_checks++; if (out_spike_count !== 8'd4 || enable !== 1'b1) begin n_errors++; $display("FAIL midrst_running: cnt=%0d en=%b want 4 1", out_spike_count, enable); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({enable, input_spike, done, cmd_ready} !== 4'b0) begin n_errors++; $display("FAIL midrst_ctrl: en/spk/done/rdy=%b want 0000", {enable, input_spike, done, cmd_ready}); end
    n_checks++; if ({out_spike_count, peak_potential, neuron_config} !== 40'h0) begin n_errors++; $display("FAIL midrst_values: cnt=%0d peak=%h cfg=%h want 0", out_spike_count, peak_potential, neuron_config); end
    rst = 1'b0; output_spike = 1'b0; membrane_potential = '0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
    $display("reset_mid_run: outputs cleared, ready after release");
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_config = '0; cmd_period = '0; cmd_num_spikes = '0;
    abort = 1'b0; output_spike = 1'b0; membrane_potential = '0;
    test_reset();
    test_basic();
    @(negedge clk);
    test_zero_spikes();
    @(negedge clk);
    test_period_zero();
    @(negedge clk);
    test_abort_back_to_back();
    @(negedge clk);
    test_saturate();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
